// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-granular arbiter sharing one 8N1 UART transmitter.
// Define ARB_TIMEOUT_EN to release an owner that idles in LOAD for TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024,
    localparam int GID_W      = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ack,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic [GID_W-1:0]        grant_id,
    output logic                    active
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t            state;
    logic [GID_W-1:0]  rr_ptr;
    logic [GID_W-1:0]  winner;
    logic [GID_W-1:0]  idx;
    logic              found;
    logic              last_q;
    logic              hi_cnt;
    logic [DATA_W-1:0] sel_data;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    // Walk downwards so the nearest index after rr_ptr is the final winner.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = GID_W'((int'(rr_ptr) + i) % N_REQ);
            if (req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign sel_data = req_data[int'(grant_id)*DATA_W +: DATA_W];

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= GID_W'(N_REQ - 1);
            last_q   <= 1'b0;
            hi_cnt   <= 1'b0;
            req_ack  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            active   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            req_ack  <= '0;
            tx_start <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            if (state != LOAD) to_cnt <= '0;
`endif
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= winner;
                        active   <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (req[grant_id] && !tx_busy) begin
                        tx_data           <= sel_data;
                        last_q            <= req_last[grant_id];
                        req_ack[grant_id] <= 1'b1;
                        tx_start          <= 1'b1;
                        hi_cnt            <= 1'b0;
                        state             <= WAIT_HI;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (!req[grant_id]) begin
                        if (to_hit) begin
                            rr_ptr <= grant_id;
                            active <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
`endif
                end
                WAIT_HI: begin
                    // Give up on a busy pulse after two cycles.
                    if (tx_busy || hi_cnt) state <= WAIT_LO;
                    else hi_cnt <= 1'b1;
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            rr_ptr <= grant_id;
                            active <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner sequences,
// and randomized frames against a frame-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } item_t;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] g;
    } tx_t;

    typedef struct packed {
        logic [3:0]      mask;
        logic [2:0]      n;
        logic [3:0][1:0] ord;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ack;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_busy = 1'b0;
    logic [1:0]     grant_id;
    logic           active;

    item_t rq[N][$];
    item_t mq[N][$];
    tx_t   tx_log[$];
    tx_t   exp_q[$];
    vec_t  vt[6];
    int    ack_cnt[N];
    int    checks = 0;
    int    failures = 0;
    int    busy_len = 3;
    bit    rand_len = 0;
    bit    ser_force = 0;
    int    ser_left = 0;
    bit    busy_fell = 0;
    logic [7:0] held = '0;
    int    m_ptr;

    uart_tx_arbiter #(
        .N_REQ(N),
        .DATA_W(W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .req_last(req_last),
        .req_ack(req_ack),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .active(active)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (rq[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req[i]          = 1'b1;
                req_data[i*W +: W] = rq[i][0].d;
                req_last[i]     = rq[i][0].l;
            end else begin
                req[i]          = 1'b0;
                req_data[i*W +: W] = 8'($urandom);
                req_last[i]     = 1'($urandom);
            end
        end
    endtask

    // One clock: observe outputs, play serializer and requesters.
    task automatic tick();
        logic       pb;
        logic [3:0] eack;
        int         k;
        pb = tx_busy;
        @(posedge clk);
        #1;
        busy_fell = 0;
        if (tx_start) begin
            chk("start_while_busy", 32'(pb), 0);
            tx_log.push_back('{d: tx_data, g: grant_id});
            held = tx_data;
            if (!ser_force) begin
                ser_left = rand_len ? int'($urandom_range(0, 5)) : busy_len;
                if (ser_left > 0) tx_busy = 1'b1;
            end
        end else if (tx_busy && !ser_force) begin
            chk("tx_data_stable", 32'(tx_data), 32'(held));
            ser_left--;
            if (ser_left <= 0) begin
                tx_busy   = 1'b0;
                busy_fell = 1;
            end
        end
        if (req_ack != '0) begin
            eack = 4'b0001 << grant_id;
            chk("ack_onehot_owner", 32'(req_ack), 32'(eack));
            k = 0;
            for (int i = N - 1; i >= 0; i--)
                if (req_ack[i]) k = i;
            checks++;
            if (rq[k].size() == 0) begin
                failures++;
                $display("FAIL ack_no_req: ack to %0d with no byte pending", k);
            end else begin
                void'(rq[k].pop_front());
            end
            ack_cnt[k]++;
        end
        drive_reqs();
    endtask

    task automatic run_until_idle(input int bound, input string name);
        int n;
        n = 0;
        while (n < bound && !(all_empty() && !active && !tx_busy)) begin
            tick();
            n++;
        end
        chk({name, "_done"}, 32'(n < bound), 1);
    endtask

    task automatic expect_log(input string name);
        chk({name, "_count"}, tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), 32'(tx_log[i].d), 32'(exp_q[i].d));
            chk($sformatf("%s_gid%0d", name, i), 32'(tx_log[i].g), 32'(exp_q[i].g));
        end
    endtask

    task automatic clear_logs();
        tx_log.delete();
        exp_q.delete();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    endtask

    initial begin
        int n;
        vt[0] = '{mask: 4'b1011, n: 3'd3, ord: 8'b00_11_01_00};
        vt[1] = '{mask: 4'b1011, n: 3'd3, ord: 8'b00_11_01_00};
        vt[2] = '{mask: 4'b0110, n: 3'd2, ord: 8'b00_00_10_01};
        vt[3] = '{mask: 4'b1001, n: 3'd2, ord: 8'b00_00_00_11};
        vt[4] = '{mask: 4'b1111, n: 3'd4, ord: 8'b00_11_10_01};
        vt[5] = '{mask: 4'b0101, n: 3'd2, ord: 8'b00_00_00_10};

        // Reset values.
        clear_logs();
        drive_reqs();
        repeat (3) tick();
        chk("rst_req_ack", 32'(req_ack), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_active", 32'(active), 0);
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_no_req", 32'(active), 0);

        // Round-robin vector table.
        busy_len = 3;
        for (int v = 0; v < 6; v++) begin
            clear_logs();
            for (int j = 0; j < N; j++)
                if (vt[v].mask[j]) rq[j].push_back('{d: 8'hA0 + 8'(j), l: 1'b1});
            drive_reqs();
            run_until_idle(400, $sformatf("rr%0d", v));
            for (int k = 0; k < int'(vt[v].n); k++)
                exp_q.push_back('{d: 8'hA0 + 8'(vt[v].ord[k]), g: vt[v].ord[k]});
            expect_log($sformatf("rr%0d", v));
        end

        // Frame lock: requester 0 waits behind a 3-byte frame.
        clear_logs();
        busy_len = 4;
        rq[1].push_back('{d: 8'h10, l: 1'b0});
        rq[1].push_back('{d: 8'h11, l: 1'b0});
        rq[1].push_back('{d: 8'h12, l: 1'b1});
        rq[0].push_back('{d: 8'h05, l: 1'b1});
        drive_reqs();
        run_until_idle(400, "lock");
        exp_q.push_back('{d: 8'h10, g: 2'd1});
        exp_q.push_back('{d: 8'h11, g: 2'd1});
        exp_q.push_back('{d: 8'h12, g: 2'd1});
        exp_q.push_back('{d: 8'h05, g: 2'd0});
        expect_log("lock");

        // Single 2-byte frame with a slow serializer.
        clear_logs();
        busy_len = 100;
        rq[2].push_back('{d: 8'h48, l: 1'b0});
        rq[2].push_back('{d: 8'h49, l: 1'b1});
        drive_reqs();
        n = 0;
        while (n < 1500 && !(busy_fell && tx_log.size() == 2)) begin
            tick();
            n++;
        end
        chk("single_wait", 32'(n < 1500), 1);
        chk("single_active_hold", 32'(active), 1);
        tick();
        chk("single_active_drop", 32'(active), 0);
        chk("single_grant", 32'(grant_id), 2);
        exp_q.push_back('{d: 8'h48, g: 2'd2});
        exp_q.push_back('{d: 8'h49, g: 2'd2});
        expect_log("single");
        for (int i = 0; i < N; i++)
            chk($sformatf("single_acks%0d", i), ack_cnt[i], (i == 2) ? 2 : 0);

        // Serializer already busy when the request appears.
        clear_logs();
        busy_len = 5;
        ser_force = 1;
        tx_busy = 1'b1;
        rq[3].push_back('{d: 8'h33, l: 1'b1});
        drive_reqs();
        repeat (10) tick();
        chk("busy_entry_nostart", tx_log.size(), 0);
        chk("busy_entry_grant", 32'(grant_id), 3);
        ser_force = 0;
        tx_busy = 1'b0;
        tick();
        chk("busy_entry_start", tx_log.size(), 1);
        run_until_idle(100, "busy_entry");
        exp_q.push_back('{d: 8'h33, g: 2'd3});
        expect_log("busy_entry");

        // Owner 2 stalls mid-frame while requester 1 waits.
        clear_logs();
        busy_len = 4;
        rq[2].push_back('{d: 8'h20, l: 1'b0});
        drive_reqs();
        repeat (2) tick();
        rq[1].push_back('{d: 8'h31, l: 1'b1});
        drive_reqs();
        n = 0;
        while (n < 100 && !(busy_fell && tx_log.size() == 1)) begin
            tick();
            n++;
        end
        chk("stall_wait", 32'(n < 100), 1);
        repeat (8) tick();
        chk("stall_grant", 32'(grant_id), 2);
        chk("stall_active", 32'(active), 1);
        exp_q.push_back('{d: 8'h20, g: 2'd2});
`ifdef ARB_TIMEOUT_EN
        run_until_idle(200, "timeout");
        exp_q.push_back('{d: 8'h31, g: 2'd1});
        expect_log("timeout");
        chk("timeout_acks2", ack_cnt[2], 1);
`else
        repeat (1000) tick();
        chk("hold_grant", 32'(grant_id), 2);
        chk("hold_count", tx_log.size(), 1);
        rq[2].push_back('{d: 8'h21, l: 1'b1});
        drive_reqs();
        run_until_idle(200, "hold");
        exp_q.push_back('{d: 8'h21, g: 2'd2});
        exp_q.push_back('{d: 8'h31, g: 2'd1});
        expect_log("hold");
`endif

        // Reset in WAIT_LO of a 2-byte frame.
        clear_logs();
        busy_len = 20;
        rq[0].push_back('{d: 8'h5A, l: 1'b0});
        rq[0].push_back('{d: 8'h5B, l: 1'b1});
        drive_reqs();
        n = 0;
        while (n < 100 && !(tx_log.size() == 1 && tx_busy)) begin
            tick();
            n++;
        end
        chk("midrst_wait", 32'(n < 100), 1);
        repeat (2) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_req_ack", 32'(req_ack), 0);
        chk("midrst_tx_start", 32'(tx_start), 0);
        chk("midrst_tx_data", 32'(tx_data), 0);
        chk("midrst_grant", 32'(grant_id), 0);
        chk("midrst_active", 32'(active), 0);
        rq[0].delete();
        tx_busy = 1'b0;
        ser_left = 0;
        drive_reqs();
        repeat (2) tick();
        chk("midrst_acks0", ack_cnt[0], 1);
        rst = 1'b1;
        clear_logs();
        busy_len = 3;
        rq[0].push_back('{d: 8'h60, l: 1'b1});
        rq[3].push_back('{d: 8'h63, l: 1'b1});
        drive_reqs();
        run_until_idle(200, "postrst");
        exp_q.push_back('{d: 8'h60, g: 2'd0});
        exp_q.push_back('{d: 8'h63, g: 2'd3});
        expect_log("postrst");

        // Random frames versus a frame-level round-robin model.
        m_ptr = N - 1;
        rand_len = 1;
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            for (int i = 0; i < N; i++) begin
                int nf;
                nf = int'($urandom_range(0, 3));
                for (int f = 0; f < nf; f++) begin
                    int len;
                    len = int'($urandom_range(1, 3));
                    for (int b = 0; b < len; b++) begin
                        item_t it;
                        it.d = 8'($urandom);
                        it.l = (b == len - 1);
                        rq[i].push_back(it);
                        mq[i].push_back(it);
                    end
                end
            end
            forever begin
                int j;
                j = -1;
                for (int off = 1; off <= N && j < 0; off++)
                    if (mq[(m_ptr + off) % N].size() > 0) j = (m_ptr + off) % N;
                if (j < 0) break;
                forever begin
                    item_t it;
                    it = mq[j].pop_front();
                    exp_q.push_back('{d: it.d, g: 2'(j)});
                    if (it.l) break;
                end
                m_ptr = j;
            end
            drive_reqs();
            run_until_idle(20000, $sformatf("rand%0d", r));
            expect_log($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1 serializer driving `dout`) between N_REQ byte sources.
- Round-robin arbitration at frame granularity: a granted requester keeps the transmitter until it sends a byte flagged `last`.
- Sequences the transmitter byte by byte with a start/busy handshake.
- Sits between the message producers and the UART serializer inside `uart_top`.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- TIMEOUT_CYC, 1024, idle-owner cycles before forced release (used only with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester byte-valid; held until acked.
- req_data  input  N_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W].
- req_last  input  N_REQ  byte is the final byte of the requester's frame.
- req_ack  output  N_REQ  one-cycle pulse: byte consumed.
- tx_start  output  1  one-cycle pulse to the serializer.
- tx_data  output  DATA_W  byte to the serializer; stable from tx_start until tx_busy falls.
- tx_busy  input  1  serializer busy; rises within 2 cycles of tx_start.
- grant_id  output  clog2(N_REQ)  current owner index.
- active  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst=0, async) values:
  - outputs: req_ack=0, tx_start=0, tx_data=0, grant_id=0, active=0.
  - internal: state=IDLE, rr_ptr=N_REQ-1, last_q=0.
- States: IDLE, LOAD, WAIT_HI, WAIT_LO.
- IDLE:
  - If any req bit is set, pick the first set index searching rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - grant_id <= winner; go to LOAD next cycle.
  - Arbitration costs one cycle.
- LOAD:
  - When req[grant_id]=1 and tx_busy=0, in one cycle:
    - tx_data <= the selected byte;
    - last_q <= req_last[grant_id];
    - req_ack[grant_id] pulses;
    - tx_start pulses;
    - go to WAIT_HI.
  - If req[grant_id]=0: hold in LOAD with the grant locked. Other requesters are not served mid-frame.
  - If tx_busy=1 on entry: wait; never issue tx_start while busy.
- WAIT_HI:
  - Wait for tx_busy=1, then go to WAIT_LO.
  - If tx_busy is not seen within 2 cycles, go to WAIT_LO anyway (zero-length guard).
- WAIT_LO: wait for tx_busy=0, then:
  - if last_q=1: rr_ptr <= grant_id, go to IDLE (frame done);
  - else: go to LOAD.
- Latency: req set in IDLE to tx_start is 2 cycles. Consecutive bytes in one frame are separated by serializer frame time + 1 cycle.
- Fairness: after owner k finishes, k has lowest priority. Wrap: rr_ptr=N_REQ-1 searches from index 0.
- Simultaneous events:
  - A req rising in the cycle of the IDLE decision is eligible.
  - req_last of a non-owner is ignored.
  - A newly asserted req from the owner during WAIT_LO is taken next in LOAD.
- Reset mid-frame: everything returns to reset values immediately. A partial byte on the line is the serializer's responsibility. No req_ack is issued for an unsent byte.
- req_ack is never asserted for more than one requester or for more than one cycle.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter runs while in LOAD with req[grant_id]=0.
  - On reaching TIMEOUT_CYC it forces frame end: rr_ptr <= grant_id, go to IDLE, no ack.
  - The counter clears on leaving LOAD.
- Undefined: no counter. The owner holds the grant in LOAD indefinitely until its next byte.

Test Plan:
- Single frame: req[2] presents bytes 0x48, 0x49 with last on 0x49; serializer model busy for 100 cycles each -> tx_data 0x48 then 0x49, two acks to requester 2 only, grant_id=2, active drops one cycle after second busy fall.
- Round-robin: req[0], req[1], req[3] all hold one-byte frames (0xA0, 0xA1, 0xA3) from reset -> transmit order 0xA0, 0xA1, 0xA3; re-raise all three -> order repeats 0, 1, 3.
- Frame lock: requester 1 sends 3-byte frame 0x10, 0x11, 0x12(last) while req[0] stays high -> bytes 0x10..0x12 contiguous, requester 0 served only afterward.
- Busy on entry: tx_busy forced 1 when req[3] rises -> no tx_start until busy falls, then tx_start within 1 cycle.
- Reset mid-frame: assert rst=0 in WAIT_LO of a 2-byte frame -> all outputs 0 asynchronously; after release, a fresh req[0] arbitrates from index 0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYC=16): owner 2 sends non-last byte then drops req, req[1] high -> after 16 idle cycles grant_id becomes 1 and its byte is sent; without macro, grant stays 2 for 1000 cycles.
